// File: rtl/mult_job_sched_pkg.sv
// Shared definitions for the int8 matrix-multiply job sequencer.
// Holds the FSM state encoding and the element sizes used to step the
// destination and bias running addresses.
package mult_sched_pkg;

  // Sequencer states, kept as plain constants so older code can reuse them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Bias entries are int32, output elements are int8
  localparam int BIAS_ELEM_BYTES = 4;
  localparam int DST_ELEM_BYTES  = 1;

endpackage

// File: rtl/mult_job_sched_if.sv
// Job handshake between the sequencer and the MAC engine.
// master: the sequencer; drives job_valid and the job descriptor,
//         receives job_ready and the per-job completion pulse cmp_valid.
// slave:  the MAC engine side of the same bundle.
interface mult_job_sched_if #(
  parameter int REG_WIDTH = 32
) ();

  logic                 job_valid;
  logic                 job_ready;
  logic [REG_WIDTH-1:0] job_lhs_addr;
  logic [REG_WIDTH-1:0] job_rhs_addr;
  logic [REG_WIDTH-1:0] job_dst_addr;
  logic [REG_WIDTH-1:0] job_bias_addr;
  logic [REG_WIDTH-1:0] job_len;
  logic                 job_last;
  logic                 cmp_valid;

  modport master (
    output job_valid, job_lhs_addr, job_rhs_addr, job_dst_addr,
           job_bias_addr, job_len, job_last,
    input  job_ready, cmp_valid
  );

  modport slave (
    input  job_valid, job_lhs_addr, job_rhs_addr, job_dst_addr,
           job_bias_addr, job_len, job_last,
    output job_ready, cmp_valid
  );

endinterface

// File: rtl/mult_inflight_cnt.sv
// In-flight job counter.
// Ports: clk/rst (sync, active-high), clr (zero the count), inc (job
// accepted), dec (job retired), count, full (count = MAX_OUT),
// empty (count = 0). Saturates at both ends.
module mult_inflight_cnt #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  assign full  = (count == CW'(MAX_OUT));
  assign empty = (count == '0);

  // A retire pulse with nothing outstanding is dropped, so when it
  // coincides with an accept at zero the accept still counts.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CW'(1);
    end else if (inc && dec && empty) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mult_job_sched.sv
// Matrix-multiply job sequencer.
// Latches the MULT configuration on start, walks the M x N output space
// row-major and issues one dot-product job per output element, then waits
// for every issued job to retire before pulsing done.
// Ports: clk, rst (sync, active-high); start/abort pulses; configuration
// (bases, m/n/k, byte strides); job_if master handshake to the MAC engine;
// busy, done pulse, sticky aborted and cfg_err status.
module mult_job_sched
  import mult_sched_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_WIDTH-1:0] lhs_base,
  input  logic [REG_WIDTH-1:0] rhs_base,
  input  logic [REG_WIDTH-1:0] dst_base,
  input  logic [REG_WIDTH-1:0] bias_base,
  input  logic [REG_WIDTH-1:0] m,
  input  logic [REG_WIDTH-1:0] n,
  input  logic [REG_WIDTH-1:0] k,
  input  logic [REG_WIDTH-1:0] lhs_row_stride_b,
  input  logic [REG_WIDTH-1:0] rhs_row_stride_b,
  input  logic [REG_WIDTH-1:0] dst_row_stride_b,
  mult_job_sched_if.master     job_if,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 cfg_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [REG_WIDTH-1:0] ONE       = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] BIAS_STEP = REG_WIDTH'(BIAS_ELEM_BYTES);
  localparam logic [REG_WIDTH-1:0] DST_STEP  = REG_WIDTH'(DST_ELEM_BYTES);

  logic [1:0]           state;
  logic [REG_WIDTH-1:0] m_q, n_q, k_q;
  logic [REG_WIDTH-1:0] lhs_stride_q, rhs_stride_q, dst_stride_q;
  logic [REG_WIDTH-1:0] rhs_base_q, bias_base_q;
  logic [REG_WIDTH-1:0] i_q, j_q;
  logic [REG_WIDTH-1:0] lhs_q, rhs_q, dst_row_q, dst_q, bias_q;
  logic [CW-1:0]        inflight;
  logic                 full, empty;
  logic                 launch, zero_dim, accept, last_pos, drain_done;

  assign launch   = (state == ST_IDLE) && start;
  assign zero_dim = (m == '0) || (n == '0) || (k == '0);
  assign accept   = job_if.job_valid && job_if.job_ready;
  assign last_pos = (i_q == m_q - ONE) && (j_q == n_q - ONE);

  // The final retire pulse is seen here so FIN follows it by one cycle
  assign drain_done = empty || ((inflight == CW'(1)) && job_if.cmp_valid);

  assign job_if.job_valid     = (state == ST_ISSUE) && !full;
  assign job_if.job_last      = (state == ST_ISSUE) && last_pos;
  assign job_if.job_lhs_addr  = lhs_q;
  assign job_if.job_rhs_addr  = rhs_q;
  assign job_if.job_dst_addr  = dst_q;
  assign job_if.job_bias_addr = bias_q;
  assign job_if.job_len       = k_q;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

  mult_inflight_cnt #(
    .MAX_OUT (MAX_OUT),
    .CW      (CW)
  ) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .clr   (launch),
    .inc   (accept),
    .dec   (job_if.cmp_valid),
    .count (inflight),
    .full  (full),
    .empty (empty)
  );

  // Run control; an accept coinciding with abort is still counted by the
  // in-flight counter, so DRAIN waits for it as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            aborted <= 1'b0;
            cfg_err <= zero_dim;
            state   <= zero_dim ? ST_FIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DRAIN;
          end else if (accept && last_pos) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) aborted <= 1'b1;
          if (drain_done) state <= ST_FIN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Running address sums: each accept steps one column; a column wrap
  // steps the row sums and reloads the per-row rhs and bias pointers.
  // A zero bias base means no bias, so the bias pointer stays at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0; n_q <= '0; k_q <= '0;
      lhs_stride_q <= '0; rhs_stride_q <= '0; dst_stride_q <= '0;
      rhs_base_q <= '0; bias_base_q <= '0;
      i_q <= '0; j_q <= '0;
      lhs_q <= '0; rhs_q <= '0; dst_row_q <= '0; dst_q <= '0; bias_q <= '0;
    end else if (launch) begin
      m_q <= m; n_q <= n; k_q <= k;
      lhs_stride_q <= lhs_row_stride_b;
      rhs_stride_q <= rhs_row_stride_b;
      dst_stride_q <= dst_row_stride_b;
      rhs_base_q   <= rhs_base;
      bias_base_q  <= bias_base;
      i_q <= '0; j_q <= '0;
      lhs_q <= lhs_base; rhs_q <= rhs_base;
      dst_row_q <= dst_base; dst_q <= dst_base;
      bias_q <= bias_base;
    end else if (accept) begin
      if (j_q == n_q - ONE) begin
        j_q       <= '0;
        i_q       <= i_q + ONE;
        lhs_q     <= lhs_q + lhs_stride_q;
        dst_row_q <= dst_row_q + dst_stride_q;
        dst_q     <= dst_row_q + dst_stride_q;
        rhs_q     <= rhs_base_q;
        bias_q    <= bias_base_q;
      end else begin
        j_q   <= j_q + ONE;
        rhs_q <= rhs_q + rhs_stride_q;
        dst_q <= dst_q + DST_STEP;
        if (bias_base_q != '0) bias_q <= bias_q + BIAS_STEP;
      end
    end
  end

endmodule

// File: tb/tb_mult_job_sched.sv
// Self-checking bench for mult_job_sched: a job-level reference model
// (indices, outstanding-job count, completion schedule) predicts every
// descriptor, handshake and status output cycle by cycle.
module tb_mult_job_sched;

  localparam int RW      = 32;
  localparam int MAX_OUT = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [RW-1:0] lhs_base, rhs_base, dst_base, bias_base, m, n, k;
  logic [RW-1:0] lhs_stride, rhs_stride, dst_stride;
  logic          busy, done, aborted, cfg_err;

  mult_job_sched_if #(.REG_WIDTH(RW)) job_bus ();

  mult_job_sched #(.REG_WIDTH(RW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lhs_base(lhs_base), .rhs_base(rhs_base), .dst_base(dst_base),
    .bias_base(bias_base), .m(m), .n(n), .k(k),
    .lhs_row_stride_b(lhs_stride), .rhs_row_stride_b(rhs_stride),
    .dst_row_stride_b(dst_stride),
    .job_if(job_bus),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Configuration as latched by the model
  logic [RW-1:0] c_lhs, c_rhs, c_dst, c_bias, c_m, c_n, c_k, c_ls, c_rs, c_ds;

  // Job-level model state
  int exp_i, exp_j, issued, retired, inflight_m, cyc, last_due;
  bit issuing, run_active, done_due, abort_sent;
  int due_q[$];

  // Scenario knobs
  int cmp_delay, stall_at, stall_left, abort_at, cmp_budget, start_at;
  bit rand_delay, rand_ready, stall_done, abort_no_ready;

  // Observations
  int done_cyc, last_cmp_cyc, last_acc_cyc, coincide;
  logic [RW-1:0] last_lhs, last_rhs, last_dst, last_bias, last_len;

  task automatic set_cfg(input logic [RW-1:0] lb, rb, db, bb, mm, nn, kk, ls, rs, ds);
    lhs_base = lb; rhs_base = rb; dst_base = db; bias_base = bb;
    m = mm; n = nn; k = kk; lhs_stride = ls; rhs_stride = rs; dst_stride = ds;
    c_lhs = lb; c_rhs = rb; c_dst = db; c_bias = bb;
    c_m = mm; c_n = nn; c_k = kk; c_ls = ls; c_rs = rs; c_ds = ds;
  endtask

  task automatic defaults();
    cmp_delay = 2; rand_delay = 0; rand_ready = 0; stall_at = -1;
    abort_at = -1; abort_no_ready = 0; cmp_budget = -1; start_at = -1;
  endtask

  task automatic begin_run();
    @(negedge clk);
    start = 1'b1;
    job_bus.job_ready = 1'b0;
    job_bus.cmp_valid = 1'b0;
    exp_i = 0; exp_j = 0; issued = 0; retired = 0; inflight_m = 0;
    cyc = 0; last_due = -1; due_q.delete();
    issuing = 1'b1; run_active = 1'b1; done_due = 1'b0; abort_sent = 1'b0;
    stall_done = 1'b0; stall_left = 0; coincide = 0;
    done_cyc = -1; last_cmp_cyc = -1; last_acc_cyc = -1;
  endtask

  // Runs the model and the DUT side by side, one negedge per cycle, until
  // done is seen or max_cycles elapse.
  task automatic drive_run(input int max_cycles, output bit saw_done);
    logic          ready, cmp, acc, exp_valid, exp_last;
    logic [RW-1:0] e_lhs, e_rhs, e_dst, e_bias;
    int            d, due;
    saw_done = 1'b0;
    for (int t = 0; t < max_cycles; t++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == start_at);
      abort = 1'b0;
      if (cyc == 1) begin
        lhs_base = $urandom; rhs_base = $urandom; dst_base = $urandom;
        bias_base = $urandom; m = $urandom; n = $urandom; k = $urandom;
        lhs_stride = $urandom; rhs_stride = $urandom; dst_stride = $urandom;
      end
      exp_valid = issuing && (inflight_m < MAX_OUT);
      exp_last  = (RW'(exp_i) == c_m - 1) && (RW'(exp_j) == c_n - 1);
      e_lhs  = c_lhs + RW'(exp_i) * c_ls;
      e_rhs  = c_rhs + RW'(exp_j) * c_rs;
      e_dst  = c_dst + RW'(exp_i) * c_ds + RW'(exp_j);
      e_bias = (c_bias == '0) ? '0 : c_bias + RW'(4) * RW'(exp_j);

      n_tests++;
      if (job_bus.job_valid !== exp_valid) begin
        n_fail++;
        $display("[TB] FAIL job_valid cyc %0d: got %b expected %b", cyc, job_bus.job_valid, exp_valid);
      end
      n_tests++;
      if (busy !== run_active) begin
        n_fail++;
        $display("[TB] FAIL busy cyc %0d: got %b expected %b", cyc, busy, run_active);
      end
      n_tests++;
      if (done !== done_due) begin
        n_fail++;
        $display("[TB] FAIL done cyc %0d: got %b expected %b", cyc, done, done_due);
      end
      if (exp_valid) begin
        n_tests++;
        if ({job_bus.job_lhs_addr, job_bus.job_rhs_addr, job_bus.job_dst_addr,
             job_bus.job_bias_addr, job_bus.job_len, job_bus.job_last} !==
            {e_lhs, e_rhs, e_dst, e_bias, c_k, exp_last}) begin
          n_fail++;
          $display("[TB] FAIL job (%0d,%0d) lhs/rhs/dst/bias/len/last: got %h %h %h %h %h %b expected %h %h %h %h %h %b",
                   exp_i, exp_j, job_bus.job_lhs_addr, job_bus.job_rhs_addr, job_bus.job_dst_addr,
                   job_bus.job_bias_addr, job_bus.job_len, job_bus.job_last,
                   e_lhs, e_rhs, e_dst, e_bias, c_k, exp_last);
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc; run_active = 1'b0; done_due = 1'b0; saw_done = 1'b1;
        start = 1'b0; job_bus.job_ready = 1'b0; job_bus.cmp_valid = 1'b0;
        break;
      end

      if (stall_left > 0) begin
        ready = 1'b0; stall_left--;
      end else if (!stall_done && stall_at >= 0 && issued == stall_at && issuing) begin
        ready = 1'b0; stall_done = 1'b1; stall_left = 4;
      end else begin
        ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      cmp = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc && cmp_budget != 0) begin
        cmp = 1'b1;
        void'(due_q.pop_front());
        if (cmp_budget > 0) cmp_budget--;
      end

      if (abort_at >= 0 && !abort_sent && issuing && issued == abort_at) begin
        abort = 1'b1; abort_sent = 1'b1;
        if (abort_no_ready) ready = 1'b0;
      end

      job_bus.job_ready = ready;
      job_bus.cmp_valid = cmp;

      acc = (job_bus.job_valid === 1'b1) && ready;
      if (acc) begin
        if (cmp) coincide++;
        if (exp_last) begin
          last_lhs = job_bus.job_lhs_addr; last_rhs = job_bus.job_rhs_addr;
          last_dst = job_bus.job_dst_addr; last_bias = job_bus.job_bias_addr;
          last_len = job_bus.job_len;
        end
        issued++; inflight_m++; last_acc_cyc = cyc;
        d   = rand_delay ? int'($urandom_range(1, 4)) : cmp_delay;
        due = (cyc + d > last_due + 1) ? cyc + d : last_due + 1;
        due_q.push_back(due); last_due = due;
        if (RW'(exp_j) == c_n - 1) begin
          exp_j = 0;
          if (RW'(exp_i) == c_m - 1) issuing = 1'b0;
          exp_i++;
        end else begin
          exp_j++;
        end
      end
      if (abort) issuing = 1'b0;
      if (cmp) begin
        retired++; last_cmp_cyc = cyc;
        if (inflight_m > 0) inflight_m--;
      end
      done_due = run_active && !issuing && (inflight_m == 0);
    end
    start = 1'b0; abort = 1'b0; job_bus.cmp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    job_bus.job_ready = 1'b0; job_bus.cmp_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({job_bus.job_valid, job_bus.job_last, busy, done, aborted, cfg_err} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset flags: got %b expected 000000",
               {job_bus.job_valid, job_bus.job_last, busy, done, aborted, cfg_err});
    end
    n_tests++;
    if ({job_bus.job_lhs_addr, job_bus.job_rhs_addr, job_bus.job_dst_addr,
         job_bus.job_bias_addr, job_bus.job_len} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset buses: got %h %h %h %h %h expected all 0",
               job_bus.job_lhs_addr, job_bus.job_rhs_addr, job_bus.job_dst_addr,
               job_bus.job_bias_addr, job_bus.job_len);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    defaults();
    set_cfg(32'h1000, 32'h2000, 32'h3000, 32'h4000, 2, 3, 16, 16, 16, 3);
    begin_run();
    drive_run(200, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("[TB] FAIL basic timeout: got no done expected done"); end
    n_tests++;
    if ({last_lhs, last_rhs, last_dst, last_bias, last_len} !==
        {32'h1010, 32'h2020, 32'h3005, 32'h4008, 32'd16}) begin
      n_fail++;
      $display("[TB] FAIL basic last job: got %h %h %h %h %h expected 1010 2020 3005 4008 10",
               last_lhs, last_rhs, last_dst, last_bias, last_len);
    end
    n_tests++;
    if (issued != 6 || retired != 6 || last_acc_cyc != 6) begin
      n_fail++;
      $display("[TB] FAIL basic counts: got issued %0d retired %0d last accept cyc %0d expected 6 6 6",
               issued, retired, last_acc_cyc);
    end
    n_tests++;
    if (done_cyc != last_cmp_cyc + 1) begin
      n_fail++;
      $display("[TB] FAIL basic done timing: got cyc %0d expected %0d", done_cyc, last_cmp_cyc + 1);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done, aborted, cfg_err} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL basic idle after done: got %b expected 0000", {busy, done, aborted, cfg_err});
    end
  endtask

  task automatic test_max_out();
    bit ok;
    defaults();
    cmp_delay = 1; cmp_budget = 0;
    set_cfg(32'h100, 32'h200, 32'h300, 32'h400, 2, 4, 8, 8, 8, 4);
    begin_run();
    drive_run(10, ok);
    n_tests++;
    if (issued != MAX_OUT || job_bus.job_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_out cap: got issued %0d valid %b expected %0d 0", issued, job_bus.job_valid, MAX_OUT);
    end
    cmp_budget = 1;
    drive_run(6, ok);
    n_tests++;
    if (issued != MAX_OUT + 1 || job_bus.job_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_out refill: got issued %0d valid %b expected %0d 0", issued, job_bus.job_valid, MAX_OUT + 1);
    end
    cmp_budget = -1;
    drive_run(200, ok);
    n_tests++;
    if (!ok || issued != 8 || retired != 8) begin
      n_fail++;
      $display("[TB] FAIL max_out finish: got done %b issued %0d retired %0d expected 1 8 8", ok, issued, retired);
    end
  endtask

  task automatic test_stall();
    bit ok;
    defaults();
    stall_at = 2; cmp_delay = 3;
    set_cfg(32'hFFFF_FFF0, 32'h10, 32'h20, 32'h30, 2, 3, 5, 32'h20, 7, 32'hFFFF_FFFE);
    begin_run();
    drive_run(200, ok);
    n_tests++;
    if (!ok || issued != 6 || retired != 6 || !stall_done) begin
      n_fail++;
      $display("[TB] FAIL stall run: got done %b issued %0d retired %0d expected 1 6 6", ok, issued, retired);
    end
  endtask

  task automatic test_zero_dim();
    bit ok;
    defaults();
    set_cfg(1, 2, 3, 4, 3, 0, 9, 1, 1, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++;
    if ({done, cfg_err, busy, job_bus.job_valid} !== 4'b1110) begin
      n_fail++;
      $display("[TB] FAIL zero_dim t+1: got done/cfg_err/busy/valid %b expected 1110",
               {done, cfg_err, busy, job_bus.job_valid});
    end
    @(negedge clk);
    n_tests++;
    if ({done, cfg_err, busy, job_bus.job_valid} !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL zero_dim t+2: got done/cfg_err/busy/valid %b expected 0100",
               {done, cfg_err, busy, job_bus.job_valid});
    end
    set_cfg(1, 2, 3, 4, 1, 2, 9, 1, 1, 1);
    begin_run();
    drive_run(1, ok);
    n_tests++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_dim clear: got cfg_err %b expected 0", cfg_err);
    end
    drive_run(100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("[TB] FAIL zero_dim rerun: got no done expected done"); end
  endtask

  task automatic test_abort(input bit no_ready, input int exp_jobs);
    bit ok;
    defaults();
    cmp_delay = 3; abort_at = 2; abort_no_ready = no_ready;
    set_cfg(32'h500, 32'h600, 32'h700, 32'h0, 3, 3, 4, 4, 4, 3);
    begin_run();
    drive_run(200, ok);
    n_tests++;
    if (!ok || issued != exp_jobs || retired != exp_jobs || aborted !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort: got done %b issued %0d retired %0d aborted %b expected 1 %0d %0d 1",
               ok, issued, retired, aborted, exp_jobs, exp_jobs);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    defaults();
    start_at = 3;
    set_cfg(32'h8000, 32'h9000, 32'hA000, 32'hB000, 3, 2, 12, 12, 12, 2);
    begin_run();
    drive_run(200, ok);
    n_tests++;
    if (!ok || issued != 6 || retired != issued || coincide == 0 || aborted !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_start: got done %b issued %0d retired %0d coincide %0d aborted %b cfg_err %b expected 1 6 6 >0 0 0",
               ok, issued, retired, coincide, aborted, cfg_err);
    end
  endtask

  task automatic test_random();
    bit ok;
    int jobs;
    for (int r = 0; r < 4; r++) begin
      defaults();
      rand_ready = 1'b1; rand_delay = 1'b1;
      set_cfg($urandom, $urandom, $urandom, (r == 1) ? 32'h0 : $urandom,
              $urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 200),
              $urandom, $urandom, $urandom);
      jobs = int'(c_m) * int'(c_n);
      begin_run();
      drive_run(400, ok);
      n_tests++;
      if (!ok || issued != jobs || retired != jobs) begin
        n_fail++;
        $display("[TB] FAIL random run %0d: got done %b issued %0d retired %0d expected 1 %0d %0d",
                 r, ok, issued, retired, jobs, jobs);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    defaults();
    set_cfg(32'h40, 32'h50, 32'h60, 32'h70, 3, 3, 3, 1, 1, 1);
    begin_run();
    drive_run(3, ok);
    rst = 1'b1; job_bus.job_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({busy, done, job_bus.job_valid, job_bus.job_last} !== 4'b0 || job_bus.job_lhs_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got busy/done/valid/last %b lhs %h expected 0000 0",
               {busy, done, job_bus.job_valid, job_bus.job_last}, job_bus.job_lhs_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_out();
    test_stall();
    test_zero_dim();
    test_abort(1'b1, 2);
    test_abort(1'b0, 3);
    test_busy_start();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_job_sched.md
# mult_job_sched

Sequencer for the int8 matrix-multiply accelerator. Latches the configuration that the MULT CSR group exposes (pointers, M/N/K, byte strides) on a start pulse. It then walks the M×N output space in row-major order and issues one dot-product job per output element to the MAC engine over a valid/ready handshake. It tracks in-flight jobs against completion pulses and signals done when every issued job has retired.

## Interface
- REG_WIDTH, 32, width of config and address buses
- MAX_OUT, 4, maximum jobs in flight (≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run when idle
- abort  in  1  pulse; stop issuing, drain in-flight jobs
- lhs_base, rhs_base, dst_base, bias_base  in  REG_WIDTH each  byte pointers
- m, n, k  in  REG_WIDTH each  rows of A / output channels / inner length
- lhs_row_stride_b, rhs_row_stride_b, dst_row_stride_b  in  REG_WIDTH each  byte strides
- job_valid  out  1  job descriptor valid
- job_ready  in  1  MAC engine accepts job
- job_lhs_addr, job_rhs_addr, job_dst_addr, job_bias_addr  out  REG_WIDTH each  per-job addresses
- job_len  out  REG_WIDTH  inner length (latched k)
- job_last  out  1  final job of run
- cmp_valid  in  1  one pulse per retired job
- busy  out  1  run active
- done  out  1  one-cycle pulse at run end
- aborted  out  1  last run ended by abort; sticky until next start
- cfg_err  out  1  last run had m, n or k equal to 0; sticky until next start

## Operation
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE + start:
  - latch all config inputs; clear aborted and cfg_err; zero the indices i, j and the in-flight count.
  - If any of m, n, k is 0: set cfg_err, go to FIN, issue no jobs.
  - Otherwise go to ISSUE.
- start outside IDLE is ignored. Config inputs are not sampled after latching.
- Job (i,j) addresses:
  - lhs = lhs_base + i·lhs_stride
  - rhs = rhs_base + j·rhs_stride
  - dst = dst_base + i·dst_stride + j
  - bias = bias_base + 4·j, or 0 when bias_base = 0 (bias disabled)
  - All sums wrap modulo 2^REG_WIDTH.
  - Use running-sum registers, not multipliers: j increments → rhs += rhs_stride, dst += 1, bias += 4. j wraps to 0 → i++, lhs += lhs_stride, row-dst += dst_stride, and rhs and bias reload their bases.
- ISSUE:
  - job_valid = 1 while inflight < MAX_OUT.
  - On job_valid & job_ready: advance the indices.
  - job_last = (i = m−1 and j = n−1). Accepting the last job goes to DRAIN.
- In-flight count:
  - +1 on accept, −1 on cmp_valid; both in the same cycle leave it unchanged.
  - cmp_valid at count 0 is ignored (no underflow).
- DRAIN: wait for inflight = 0, then go to FIN.
- abort in ISSUE or DRAIN:
  - set aborted; job_valid drops next cycle; go to DRAIN.
  - If job_valid & job_ready coincide with abort, that job counts as issued.
- abort in IDLE or FIN is ignored.
- FIN: done = 1 for one cycle, then IDLE.
- busy = 1 in ISSUE, DRAIN, FIN.

## Timing
- Reset values:
  - state IDLE
  - job_valid, job_last, busy, done, aborted, cfg_err = 0
  - all job_* buses and counters = 0
- start at cycle t → busy and job_valid high at t+1, with job (0,0) on the bus.
- Back-to-back issue: one job per cycle while job_ready = 1 and inflight < MAX_OUT.
- Valid/ready rules:
  - job_* are registered outputs, held stable while job_valid & !job_ready.
  - job_valid never deasserts without acceptance, except on abort or rst.
- Last cmp_valid at cycle c with inflight = 1 → FIN at c+1 (done = 1) → IDLE at c+2.
- A new start is accepted at c+2.
- Zero-dimension run: start at t → done at t+1.
- rst mid-run returns the block to IDLE immediately. The in-flight record is lost; the MAC engine must be reset together with this block.

## Structure
- Shared package mult_sched_pkg:
  - state encoding localparams (IDLE=0, ISSUE=1, DRAIN=2, FIN=3)
  - bias element size (4 bytes)
  - dst element size (1 byte)
- One sub-module, mult_inflight_cnt:
  - up/down counter saturating at MAX_OUT and 0
  - outputs full (count = MAX_OUT) and empty (count = 0)
- Address running sums and the FSM live in the top level.

## Test plan
- m=2, n=3, k=16, lhs_base=0x1000, lhs_stride=16, rhs_base=0x2000, rhs_stride=16, dst_base=0x3000, dst_stride=3, bias_base=0x4000, job_ready=1, cmp 2 cycles after each accept → 6 jobs in order (0,0)…(1,2). Job (1,2) has lhs=0x1010, rhs=0x2020, dst=0x3005, bias=0x4008, len=16, job_last=1. done one cycle after the 6th cmp.
- MAX_OUT=4, cmp_valid held 0 → exactly 4 accepts, then job_valid=0. One cmp pulse → exactly one more job issued.
- job_ready low for 5 cycles mid-run → job_* stable throughout, no skipped or duplicated (i,j).
- n=0 (others nonzero) → no job_valid, done at t+1, cfg_err=1. Next valid start clears cfg_err.
- abort after 2 accepts, with 2 in flight → job_valid low next cycle, done after 2 cmps, aborted=1. bias_base=0 run → every job_bias_addr=0.
- start asserted while busy, and a cmp_valid coincident with an accept → start ignored; in-flight count unchanged; total cmps equal total jobs at done.
